// File: rtl/opb_slv_pkg.sv
// Shared definitions for the OPB slave register bank: data/byte-enable widths, the
// word index width (64 registers max), the transfer FSM state type and a byte-merge
// helper. Optional feature macro used by the top level: OPB_SLV_ERRACK_EN.
package opb_slv_pkg;

   localparam int OPB_DW    = 32;
   localparam int OPB_BEW   = 4;
   localparam int OPB_IDX_W = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACK  = 2'd1,
      DONE = 2'd2
   } slv_state_t;

   // be[OPB_BEW-1] is OPB_BE[0], which selects the most significant byte
   // (DBus[0:7] in big-endian bit numbering).
   function automatic logic [OPB_DW-1:0] be_merge(input logic [OPB_DW-1:0]  old_w,
                                                  input logic [OPB_DW-1:0]  new_w,
                                                  input logic [OPB_BEW-1:0] be);
      logic [OPB_DW-1:0] w;
      w = old_w;
      for (int b = 0; b < OPB_BEW; b++) begin
         if (be[b]) w[8*b +: 8] = new_w[8*b +: 8];
      end
      return w;
   endfunction

endpackage

// File: rtl/opb_slv_addr_decode.sv
// OPB address window decoder: flags a selected address inside [C_BASEADDR, C_HIGHADDR]
// and extracts the 32-bit word index relative to the base. Purely combinational.
// Ports: select/abus in; hit, idx (low OPB_IDX_W bits), idx_ovf (index beyond idx range) out.
module opb_slv_addr_decode
   import opb_slv_pkg::*;
#(
   parameter logic [31:0] C_BASEADDR = 32'h0100_0000,
   parameter logic [31:0] C_HIGHADDR = 32'h0100_00FF
) (
   input  logic                 select,
   input  logic [31:0]          abus,
   output logic                 hit,
   output logic [OPB_IDX_W-1:0] idx,
   output logic                 idx_ovf
);

   logic [31:0] offset;
   logic        unused_offset_lsb;

   assign offset  = abus - C_BASEADDR;
   assign hit     = select && (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);
   assign idx     = offset[OPB_IDX_W+1:2];
   // Word index too large for the idx field; the register bank treats it as out of range.
   assign idx_ovf = |offset[31:OPB_IDX_W+2];

   // Byte offset within a word is irrelevant: every access is word-granular.
   assign unused_offset_lsb = ^offset[1:0];

endmodule

// File: rtl/opb_sw_reg_slave.sv
// OPB slave exposing C_NUM_REGS 32-bit software registers to fabric with per-register strobes.
// Ports: OPB bus inputs (OPB_*), slave responses (Sl_*), reg_out/reg_in register bus, wr/rd strobes.
// Macro OPB_SLV_ERRACK_EN: out-of-range and read-only writes answer with Sl_errAck instead.
module opb_sw_reg_slave
   import opb_slv_pkg::*;
#(
   parameter logic [31:0] C_BASEADDR = 32'h0100_0000,
   parameter logic [31:0] C_HIGHADDR = 32'h0100_00FF,
   parameter int          C_NUM_REGS = 8,
   parameter logic [63:0] C_RO_MASK  = 64'h0
) (
   input  logic                    OPB_Clk,
   input  logic                    OPB_Rst_n,
   input  logic                    OPB_select,
   input  logic                    OPB_RNW,
   input  logic [0:3]              OPB_BE,
   input  logic [0:31]             OPB_ABus,
   input  logic [0:31]             OPB_DBus,
   input  logic                    OPB_seqAddr,
   output logic                    Sl_xferAck,
   output logic                    Sl_errAck,
   output logic                    Sl_toutSup,
   output logic                    Sl_retry,
   output logic [0:31]             Sl_DBus,
   output logic [32*C_NUM_REGS-1:0] reg_out,
   input  logic [32*C_NUM_REGS-1:0] reg_in,
   output logic [C_NUM_REGS-1:0]   reg_wr_stb,
   output logic [C_NUM_REGS-1:0]   reg_rd_stb
);

   localparam logic [OPB_IDX_W:0] NUM_REGS_C = (OPB_IDX_W+1)'(C_NUM_REGS);

   logic [1:0]            rst_sync;
   logic                  rst_n;
   slv_state_t            state;

   logic                  hit;
   logic [OPB_IDX_W-1:0]  idx;
   logic                  idx_ovf;
   logic                  in_range;

   logic [OPB_IDX_W-1:0]  idx_q;
   logic                  rnw_q;
   logic                  ok_q;
   logic [OPB_BEW-1:0]    be_q;
   logic [OPB_DW-1:0]     dat_q;

   logic [C_NUM_REGS-1:0] sel_vec;
   logic [OPB_DW-1:0]     rd_word;
   logic                  ro_hit;
   logic                  acc_err;
   logic                  wr_ok;
   logic                  rd_ok;
   logic                  wr_data_en;

   logic                  xfer_ack_q;
   logic                  err_ack_q;
   logic                  tout_q;
   logic [OPB_DW-1:0]     dbus_q;
   logic [C_NUM_REGS-1:0] wr_stb_q;
   logic [C_NUM_REGS-1:0] rd_stb_q;
   logic                  unused_seq;

   // Reset asserts immediately but releases only after two clean clock edges.
   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) rst_sync <= 2'b00;
      else            rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n = rst_sync[1];

   opb_slv_addr_decode #(
      .C_BASEADDR (C_BASEADDR),
      .C_HIGHADDR (C_HIGHADDR)
   ) u_decode (
      .select  (OPB_select),
      .abus    (OPB_ABus),
      .hit     (hit),
      .idx     (idx),
      .idx_ovf (idx_ovf)
   );

   assign in_range = !idx_ovf && ({1'b0, idx} < NUM_REGS_C);

   // Decode of the captured index: one-hot select, read-back word, read-only flag.
   // Read-only registers return the live fabric value rather than the stored word.
   always_comb begin
      sel_vec = '0;
      rd_word = '0;
      ro_hit  = 1'b0;
      for (int i = 0; i < C_NUM_REGS; i++) begin
         if (ok_q && (idx_q == OPB_IDX_W'(i))) begin
            sel_vec[i] = 1'b1;
            ro_hit     = C_RO_MASK[i];
            rd_word    = C_RO_MASK[i] ? reg_in[32*i +: 32] : reg_out[32*i +: 32];
         end
      end
   end

`ifdef OPB_SLV_ERRACK_EN
   assign acc_err = !ok_q || (!rnw_q && ro_hit);
`else
   assign acc_err = 1'b0;
`endif

   // A write to a read-only register still strobes; only the data is dropped.
   assign wr_ok      = !rnw_q && ok_q && !acc_err;
   assign rd_ok      = rnw_q && ok_q && !acc_err;
   assign wr_data_en = (state == ACK) && wr_ok && !ro_hit;

   // Transfer FSM with registered bus outputs. Pulses default low every cycle, so
   // ack/strobes last exactly one cycle; DONE absorbs the cycle in which the master
   // is still dropping select, which rules out a second ack for the same beat.
   always_ff @(posedge OPB_Clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         idx_q      <= '0;
         rnw_q      <= 1'b0;
         ok_q       <= 1'b0;
         be_q       <= '0;
         dat_q      <= '0;
         xfer_ack_q <= 1'b0;
         err_ack_q  <= 1'b0;
         tout_q     <= 1'b0;
         dbus_q     <= '0;
         wr_stb_q   <= '0;
         rd_stb_q   <= '0;
      end else begin
         xfer_ack_q <= 1'b0;
         err_ack_q  <= 1'b0;
         dbus_q     <= '0;
         wr_stb_q   <= '0;
         rd_stb_q   <= '0;
         case (state)
            IDLE: begin
               if (hit) begin
                  idx_q  <= idx;
                  rnw_q  <= OPB_RNW;
                  ok_q   <= in_range;
                  be_q   <= OPB_BE;
                  dat_q  <= OPB_DBus;
                  tout_q <= 1'b1;
                  state  <= ACK;
               end
            end
            ACK: begin
               // Select is not re-checked: an aborted beat still finishes cleanly.
               tout_q <= 1'b1;
               if (acc_err) err_ack_q  <= 1'b1;
               else         xfer_ack_q <= 1'b1;
               if (rd_ok) begin
                  dbus_q   <= rd_word;
                  rd_stb_q <= sel_vec;
               end
               if (wr_ok) wr_stb_q <= sel_vec;
               state <= DONE;
            end
            DONE: begin
               tout_q <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               tout_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_reg
      logic [OPB_DW-1:0] r;
      always_ff @(posedge OPB_Clk or negedge rst_n) begin
         if (!rst_n)                       r <= '0;
         else if (wr_data_en && sel_vec[g]) r <= be_merge(r, dat_q, be_q);
      end
      assign reg_out[32*g +: 32] = r;
   end

   assign Sl_xferAck = xfer_ack_q;
   assign Sl_errAck  = err_ack_q;
   assign Sl_toutSup = tout_q;
   assign Sl_retry   = 1'b0;
   assign Sl_DBus    = dbus_q;
   assign reg_wr_stb = wr_stb_q;
   assign reg_rd_stb = rd_stb_q;

   // Every beat is decoded as a single transfer.
   assign unused_seq = OPB_seqAddr;

endmodule

// File: tb/tb_opb_sw_reg_slave.sv
// Directed bench for opb_sw_reg_slave: stimulus pushes expected acknowledges into a
// scoreboard queue; a negedge monitor pops and compares on every ack and checks the
// bus is quiet otherwise. Register 2 is read-only, backed by reg_in.
module tb_opb_sw_reg_slave;

   localparam logic [31:0] BASE = 32'h0100_0000;
   localparam logic [31:0] HIGH = 32'h0100_00FF;
`ifdef OPB_SLV_ERRACK_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          opb_select = 1'b0;
   logic          opb_rnw = 1'b0;
   logic [0:3]    opb_be = 4'b0000;
   logic [0:31]   opb_abus = '0;
   logic [0:31]   opb_dbus = '0;
   logic          opb_seq = 1'b0;
   logic          xfer_ack, err_ack, tout_sup, retry;
   logic [0:31]   sl_dbus;
   logic [255:0]  reg_out;
   logic [255:0]  reg_in = '0;
   logic [7:0]    wr_stb, rd_stb;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   bit mon_en = 1'b0;

   typedef struct {
      int         cyc;
      logic [1:0] kind;   // {errAck, xferAck}
      logic [31:0] rdat;
      logic [7:0] wstb;
      logic [7:0] rstb;
   } exp_t;
   exp_t sb[$];

   opb_sw_reg_slave #(
      .C_BASEADDR (BASE),
      .C_HIGHADDR (HIGH),
      .C_NUM_REGS (8),
      .C_RO_MASK  (64'h4)
   ) dut (
      .OPB_Clk     (clk),
      .OPB_Rst_n   (rst_n),
      .OPB_select  (opb_select),
      .OPB_RNW     (opb_rnw),
      .OPB_BE      (opb_be),
      .OPB_ABus    (opb_abus),
      .OPB_DBus    (opb_dbus),
      .OPB_seqAddr (opb_seq),
      .Sl_xferAck  (xfer_ack),
      .Sl_errAck   (err_ack),
      .Sl_toutSup  (tout_sup),
      .Sl_retry    (retry),
      .Sl_DBus     (sl_dbus),
      .reg_out     (reg_out),
      .reg_in      (reg_in),
      .reg_wr_stb  (wr_stb),
      .reg_rd_stb  (rd_stb)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: compare every acknowledge against the scoreboard; otherwise the OR-bus must be quiet.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (xfer_ack || err_ack) begin
               if (sb.size() == 0) begin
                  chk("unexpected_ack", {err_ack, xfer_ack}, 2'b00);
               end else begin
                  e = sb.pop_front();
                  chk("ack_cycle", cyc, e.cyc);
                  chk("ack_kind", {err_ack, xfer_ack}, e.kind);
                  chk("ack_dbus", sl_dbus, e.rdat);
                  chk("ack_wr_stb", wr_stb, e.wstb);
                  chk("ack_rd_stb", rd_stb, e.rstb);
               end
            end else begin
               chk("idle_dbus", sl_dbus, 0);
               chk("idle_stb", {wr_stb, rd_stb}, 0);
            end
            chk("retry", retry, 0);
         end
      end
   end

   // One bus beat. kind 0 = no response expected (select held 20 cycles, no toutSup).
   task automatic xfer(input logic [31:0] addr, input logic rnw, input logic [3:0] be,
                       input logic [31:0] dat, input logic [1:0] kind, input logic [31:0] rdat,
                       input logic [7:0] wstb, input logic [7:0] rstb, input bit abort);
      exp_t e;
      bit   seen;
      bit   tout_seen;
      @(posedge clk); #1;
      opb_abus   = addr;
      opb_rnw    = rnw;
      opb_be     = be;
      opb_dbus   = dat;
      opb_select = 1'b1;
      if (kind != 2'b00) begin
         e.cyc = cyc + 2; e.kind = kind; e.rdat = rdat; e.wstb = wstb; e.rstb = rstb;
         sb.push_back(e);
      end
      seen = 1'b0;
      tout_seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
         @(posedge clk); #1;
         if (abort && n == 0) opb_select = 1'b0;
         if (tout_sup) tout_seen = 1'b1;
         if (xfer_ack || err_ack) seen = 1'b1;
      end
      opb_select = 1'b0;
      opb_rnw    = 1'b0;
      opb_dbus   = '0;
      if (kind == 2'b00) begin
         chk("miss_no_ack", seen, 0);
         chk("miss_no_tout", tout_seen, 0);
      end else begin
         chk("ack_within_bound", seen, 1);
      end
   endtask

   initial begin
      logic [255:0] exp_regs;
      reg_in[64 +: 32] = 32'hCAFE0001;
      reg_in[96 +: 32] = 32'h1234_5678;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_xfer_ack", xfer_ack, 0);
      chk("rst_err_ack", err_ack, 0);
      chk("rst_tout", tout_sup, 0);
      chk("rst_dbus", sl_dbus, 0);
      chk("rst_regs", reg_out, 0);
      mon_en = 1'b1;

      // Full-word write, then byte-lane update and read-back.
      xfer(BASE + 32'h4, 0, 4'b1111, 32'hDEADBEEF, 2'b01, 0, 8'h02, 8'h00, 0);
      chk("reg1_full", reg_out[32 +: 32], 32'hDEADBEEF);
      xfer(BASE + 32'h4, 0, 4'b0100, 32'h11223344, 2'b01, 0, 8'h02, 8'h00, 0);
      xfer(BASE + 32'h4, 1, 4'b1111, 0, 2'b01, 32'hDE22BEEF, 8'h00, 8'h02, 0);
      chk("reg1_merge", reg_out[32 +: 32], 32'hDE22BEEF);

      // Read-only register: reads reg_in, write is dropped.
      xfer(BASE + 32'h8, 1, 4'b1111, 0, 2'b01, 32'hCAFE0001, 8'h00, 8'h04, 0);
      xfer(BASE + 32'h8, 0, 4'b1111, 32'hFFFFFFFF, ERR_EN ? 2'b10 : 2'b01, 0,
           ERR_EN ? 8'h00 : 8'h04, 8'h00, 0);
      chk("ro_reg_unchanged", reg_out[64 +: 32], 0);
      xfer(BASE + 32'h8, 1, 4'b1111, 0, 2'b01, 32'hCAFE0001, 8'h00, 8'h04, 0);

      // BE=0000 leaves the register alone; outer bytes only; stored value, not reg_in, reads back.
      xfer(BASE + 32'hC, 0, 4'b0000, 32'hAAAA5555, 2'b01, 0, 8'h08, 8'h00, 0);
      chk("be_none", reg_out[96 +: 32], 0);
      xfer(BASE + 32'hC, 0, 4'b1001, 32'hA1B2C3D4, 2'b01, 0, 8'h08, 8'h00, 0);
      xfer(BASE + 32'hC, 1, 4'b1111, 0, 2'b01, 32'hA10000D4, 8'h00, 8'h08, 0);

      // Last implemented register.
      xfer(BASE + 32'h1C, 0, 4'b1111, 32'h77770007, 2'b01, 0, 8'h80, 8'h00, 0);
      xfer(BASE + 32'h1C, 1, 4'b1111, 0, 2'b01, 32'h77770007, 8'h00, 8'h80, 0);

      // Inside the window but beyond the bank.
      xfer(BASE + 32'h40, 1, 4'b1111, 0, ERR_EN ? 2'b10 : 2'b01, 0, 8'h00, 8'h00, 0);
      xfer(BASE + 32'h20, 0, 4'b1111, 32'h12121212, ERR_EN ? 2'b10 : 2'b01, 0, 8'h00, 8'h00, 0);
      exp_regs = '0;
      exp_regs[32 +: 32]  = 32'hDE22BEEF;
      exp_regs[96 +: 32]  = 32'hA10000D4;
      exp_regs[224 +: 32] = 32'h77770007;
      chk("bank_after_oor", reg_out, exp_regs);

      // Master drops select right after it is sampled: beat still completes.
      xfer(BASE + 32'h10, 0, 4'b1111, 32'h44444444, 2'b01, 0, 8'h10, 8'h00, 1);
      chk("abort_write", reg_out[128 +: 32], 32'h44444444);

      // Outside the window on either side: silence.
      xfer(HIGH + 32'h1, 1, 4'b1111, 0, 2'b00, 0, 0, 0, 0);
      xfer(BASE - 32'h4, 0, 4'b1111, 32'hFFFFFFFF, 2'b00, 0, 0, 0, 0);

      // Reset asserted while the FSM sits in ACK.
      @(posedge clk); #1;
      opb_abus = BASE + 32'h14; opb_rnw = 1'b0; opb_be = 4'b1111;
      opb_dbus = 32'h55555555; opb_select = 1'b1;
      @(posedge clk); #1;
      chk("tout_in_ack", tout_sup, 1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_ack", xfer_ack, 0);
      chk("rst_mid_tout", tout_sup, 0);
      chk("rst_mid_regs", reg_out, 0);
      @(posedge clk); #1;
      chk("rst_mid_no_ack", {err_ack, xfer_ack}, 0);
      opb_select = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_mid_regs_after", reg_out, 0);

      // Functional again after reset; register 1 was cleared.
      xfer(BASE + 32'h4, 1, 4'b1111, 0, 2'b01, 32'h0, 8'h00, 8'h02, 0);

      repeat (4) @(posedge clk);
      #1;
      chk("scoreboard_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
